fpu_issue_arbiter: RTL

Sequencer and arbiter that shares one combinational fpu datapath (add/sub/mul/div on 32-bit IEEE-754 words, 2-bit op) among NUM_REQ requesters. It grants one requester at a time by round-robin and registers the operands onto the fpu inputs. It waits a per-op multicycle latency, captures the fpu result and returns it tagged with the requester id over a valid/ready response channel. The fpu is treated as a multicycle path, and this block owns its operand registers.

---
 rtl/fpu_issue_arbiter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/fpu_issue_arbiter.sv
// fpu_issue_arbiter: round-robin issue of operand sets from NUM_REQ requesters
// onto one shared multicycle fpu datapath. The result is captured after a
// per-op latency and returned with the requester id on a valid/ready channel.
module fpu_issue_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2,
   parameter int ADD_LAT = 2,
   parameter int MUL_LAT = 3,
   parameter int DIV_LAT = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic [32*NUM_REQ-1:0] req_a,
   input  logic [32*NUM_REQ-1:0] req_b,
   input  logic [2*NUM_REQ-1:0]  req_op,
   output logic [31:0]           fpu_a,
   output logic [31:0]           fpu_b,
   output logic [1:0]            fpu_op,
   output logic                  fpu_start,
   input  logic [31:0]           fpu_out,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [31:0]           rsp_data,
   output logic [ID_W-1:0]       rsp_id,
   output logic                  busy
);

   // Selected word layout: {id, op, b, a}
   localparam int WORD_W = ID_W + 66;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;        // first index searched for the next grant
   logic [7:0]        cnt_q, cnt_d;        // remaining cycles before capture
   logic [31:0]       fpu_a_q, fpu_a_d;
   logic [31:0]       fpu_b_q, fpu_b_d;
   logic [1:0]        fpu_op_q, fpu_op_d;
   logic              fpu_start_q, fpu_start_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [31:0]       rsp_data_q, rsp_data_d;
   logic [ID_W-1:0]   rsp_id_q, rsp_id_d;

   logic [NUM_REQ-1:0] rot_valid;
   logic [NUM_REQ-1:0] rot_oh;
   logic [NUM_REQ-1:0] grant_oh;
   logic [WORD_W-1:0]  word_terms [NUM_REQ];
   logic [WORD_W-1:0]  sel_word;
   logic [31:0]        sel_a;
   logic [31:0]        sel_b;
   logic [1:0]         sel_op;
   logic [ID_W-1:0]    sel_id;
   logic [7:0]         sel_lat_m1;
   logic               accept;

   // Rotate valids so the search start sits at bit 0, isolate the lowest set
   // bit, then rotate the one-hot back into requester order.
   assign rot_valid = NUM_REQ'({req_valid, req_valid} >> ptr_q);
   assign rot_oh    = rot_valid & (~rot_valid + NUM_REQ'(1));
   assign grant_oh  = NUM_REQ'(({rot_oh, rot_oh} << ptr_q) >> NUM_REQ);

   // Grant is offered only while idle and out of reset.
   assign req_ready = (state_q == IDLE && !rst) ? grant_oh : '0;
   assign accept    = |(req_valid & req_ready);

   // One-hot AND-OR mux of {id, op, b, a} for the granted requester.
   genvar gi, gb;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_term
         assign word_terms[gi] = {ID_W'(gi), req_op[2*gi +: 2], req_b[32*gi +: 32], req_a[32*gi +: 32]}
                                 & {WORD_W{grant_oh[gi]}};
      end
      for (gb = 0; gb < WORD_W; gb++) begin : g_col
         logic [NUM_REQ-1:0] col;
         for (gi = 0; gi < NUM_REQ; gi++) begin : g_row
            assign col[gi] = word_terms[gi][gb];
         end
         assign sel_word[gb] = |col;
      end
   endgenerate

   assign sel_a  = sel_word[31:0];
   assign sel_b  = sel_word[63:32];
   assign sel_op = sel_word[65:64];
   assign sel_id = sel_word[WORD_W-1:66];

   // Cycles to wait after the accept edge, minus one (counter reaches 0 on the capture cycle).
   always_comb begin
      case (sel_op)
         2'b10:   sel_lat_m1 = 8'(MUL_LAT - 1);
         2'b11:   sel_lat_m1 = 8'(DIV_LAT - 1);
         default: sel_lat_m1 = 8'(ADD_LAT - 1);
      endcase
   end

   // Next-state logic for the IDLE -> EXEC -> RESP sequence.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      fpu_a_d     = fpu_a_q;
      fpu_b_d     = fpu_b_q;
      fpu_op_d    = fpu_op_q;
      fpu_start_d = 1'b0;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_id_d    = rsp_id_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               fpu_a_d     = sel_a;
               fpu_b_d     = sel_b;
               fpu_op_d    = sel_op;
               fpu_start_d = 1'b1;
               rsp_id_d    = sel_id;
               cnt_d       = sel_lat_m1;
               ptr_d       = (sel_id == ID_W'(NUM_REQ - 1)) ? '0 : sel_id + ID_W'(1);
               state_d     = EXEC;
            end
         end
         EXEC: begin
            if (cnt_q == 8'd0) begin
               rsp_data_d  = fpu_out;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d     = IDLE;
            rsp_valid_d = 1'b0;
         end
      endcase
   end

   // State and output registers; reset drops any in-flight op.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         cnt_q       <= 8'd0;
         fpu_a_q     <= 32'd0;
         fpu_b_q     <= 32'd0;
         fpu_op_q    <= 2'd0;
         fpu_start_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 32'd0;
         rsp_id_q    <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         fpu_a_q     <= fpu_a_d;
         fpu_b_q     <= fpu_b_d;
         fpu_op_q    <= fpu_op_d;
         fpu_start_q <= fpu_start_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_id_q    <= rsp_id_d;
      end
   end

   assign fpu_a     = fpu_a_q;
   assign fpu_b     = fpu_b_q;
   assign fpu_op    = fpu_op_q;
   assign fpu_start = fpu_start_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_id    = rsp_id_q;
   assign busy      = (state_q != IDLE);

endmodule
